// File: rtl/fetch_pkg.sv
// Shared types and helpers for the program-counter / fetch-sequencing stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // A fetch address is legal when word aligned and inside instruction memory.
  function automatic logic is_fetch_ok(input logic [31:0] addr, input logic [31:0] depth);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Combinational next-PC priority mux with fetch-address fault check.
module next_pc_sel
  import fetch_pkg::*;
#(
  parameter int IMEM_DEPTH = 32
) (
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        last_instr_flag,
  output logic [31:0] cand,
  output logic        take,
  output logic        fault_now
);

  logic w_ok;
  logic w_advance;

  assign cand      = redirect ? redirect_target : (pc + INSTR_BYTES);
  assign w_ok      = is_fetch_ok(cand, 32'(IMEM_DEPTH));
  // The sentinel and stalls both suppress any PC movement or fault.
  assign w_advance = !last_instr_flag && !stall;
  assign take      = w_advance && w_ok;
  assign fault_now = w_advance && !w_ok;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, fetch state machine and retired-fetch counter feeding instruction memory.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_DEPTH = 32,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_target,
  input  logic             last_instr_flag,
  output logic [31:0]      imem_addr,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             fetch_valid,
  output logic             halted,
  output logic             fault,
  output logic [31:0]      fault_pc,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fetch_state_e     r_state;
  logic [31:0]      r_pc;
  logic             r_halted;
  logic             r_fault;
  logic [31:0]      r_fault_pc;
  logic [CNT_W-1:0] r_retired_cnt;

  logic [31:0] w_cand;
  logic        w_take;
  logic        w_fault_now;

  next_pc_sel #(
    .IMEM_DEPTH(IMEM_DEPTH)
  ) u_next_pc_sel (
    .pc              (r_pc),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .last_instr_flag (last_instr_flag),
    .cand            (w_cand),
    .take            (w_take),
    .fault_now       (w_fault_now)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_pc    <= 32'h0;
      r_retired_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (last_instr_flag) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else if (w_take) begin
            r_pc <= w_cand;
            if (r_retired_cnt != '1)
              r_retired_cnt <= r_retired_cnt + CNT_ONE;
          end else if (w_fault_now) begin
            r_state    <= ST_FAULT;
            r_fault    <= 1'b1;
            r_fault_pc <= w_cand;
          end
        end
        default: ;  // HALT and FAULT hold everything until reset
      endcase
    end
  end

  assign imem_addr   = {2'b00, r_pc[31:2]};
  assign pc_plus4    = r_pc + INSTR_BYTES;
  assign pc          = r_pc;
  assign fetch_valid = (r_state == ST_RUN) && !last_instr_flag;
  assign halted      = r_halted;
  assign fault       = r_fault;
  assign fault_pc    = r_fault_pc;
  assign retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit (default, run-off and narrow-counter instances).
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        last_instr_flag = 1'b0;
  logic        zero_bit = 1'b0;
  logic [31:0] zero_word = 32'h0;

  logic [31:0] a_imem_addr, a_pc, a_pc_plus4, a_fault_pc;
  logic        a_fetch_valid, a_halted, a_fault;
  logic [15:0] a_cnt;

  logic [31:0] b_imem_addr, b_pc, b_pc_plus4, b_fault_pc;
  logic        b_fetch_valid, b_halted, b_fault;
  logic [15:0] b_cnt;

  logic [31:0] c_imem_addr, c_pc, c_pc_plus4, c_fault_pc;
  logic        c_fetch_valid, c_halted, c_fault;
  logic [1:0]  c_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_fetch_unit u_dut_a (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .last_instr_flag(last_instr_flag),
    .imem_addr(a_imem_addr), .pc(a_pc), .pc_plus4(a_pc_plus4),
    .fetch_valid(a_fetch_valid), .halted(a_halted), .fault(a_fault),
    .fault_pc(a_fault_pc), .retired_cnt(a_cnt)
  );

  pc_fetch_unit #(.RESET_PC(32'h0000_0078)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .stall(zero_bit), .redirect(zero_bit),
    .redirect_target(zero_word), .last_instr_flag(zero_bit),
    .imem_addr(b_imem_addr), .pc(b_pc), .pc_plus4(b_pc_plus4),
    .fetch_valid(b_fetch_valid), .halted(b_halted), .fault(b_fault),
    .fault_pc(b_fault_pc), .retired_cnt(b_cnt)
  );

  pc_fetch_unit #(.CNT_W(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .last_instr_flag(last_instr_flag),
    .imem_addr(c_imem_addr), .pc(c_pc), .pc_plus4(c_pc_plus4),
    .fetch_valid(c_fetch_valid), .halted(c_halted), .fault(c_fault),
    .fault_pc(c_fault_pc), .retired_cnt(c_cnt)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked there after the rising edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0; last_instr_flag = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check_value("rst_pc",       a_pc, 32'h0);
    check_value("rst_imem",     a_imem_addr, 32'h0);
    check_value("rst_halted",   32'(a_halted), 32'h0);
    check_value("rst_fault",    32'(a_fault), 32'h0);
    check_value("rst_fault_pc", a_fault_pc, 32'h0);
    check_value("rst_cnt",      32'(a_cnt), 32'h0);
    check_value("rst_valid",    32'(a_fetch_valid), 32'h1);
    check_value("rst_b_pc",     b_pc, 32'h78);
    rst_n = 1'b1;

    // Free run; B runs off the end of memory, C's 2-bit counter saturates
    for (int i = 1; i <= 4; i++) begin
      step();
      check_value($sformatf("run_pc%0d", i), a_pc, 32'(4 * i));
      check_value($sformatf("run_imem%0d", i), a_imem_addr, 32'(i));
      if (i == 1) begin
        check_value("b_pc_7c", b_pc, 32'h7C);
        check_value("b_no_fault", 32'(b_fault), 32'h0);
      end
      if (i == 2) begin
        check_value("b_fault",    32'(b_fault), 32'h1);
        check_value("b_fault_pc", b_fault_pc, 32'h80);
        check_value("b_pc_hold",  b_pc, 32'h7C);
        check_value("b_valid",    32'(b_fetch_valid), 32'h0);
        check_value("b_cnt",      32'(b_cnt), 32'h1);
      end
    end
    check_value("run_cnt",   32'(a_cnt), 32'h4);
    check_value("run_plus4", a_pc_plus4, 32'd20);
    check_value("c_cnt_sat", 32'(c_cnt), 32'h3);
    check_value("b_still_fault_pc", b_pc, 32'h7C);

    // Redirect from pc=8
    do_reset();
    step(); step();
    check_value("rd_pc8", a_pc, 32'h8);
    redirect = 1'b1; redirect_target = 32'h40;
    step();
    redirect = 1'b0;
    check_value("rd_pc40",   a_pc, 32'h40);
    check_value("rd_imem16", a_imem_addr, 32'd16);
    step();
    check_value("rd_pc44",   a_pc, 32'h44);

    // Stall with redirect pending
    redirect = 1'b1; redirect_target = 32'h10;
    step();
    check_value("st_pc10",  a_pc, 32'h10);
    check_value("st_cnt5",  32'(a_cnt), 32'h5);
    stall = 1'b1; redirect_target = 32'h0;
    step(); step();
    check_value("st_pc_hold",  a_pc, 32'h10);
    check_value("st_cnt_hold", 32'(a_cnt), 32'h5);
    stall = 1'b0;
    step();
    redirect = 1'b0;
    check_value("st_pc0",  a_pc, 32'h0);
    check_value("st_cnt6", 32'(a_cnt), 32'h6);

    // Misaligned redirect target
    redirect = 1'b1; redirect_target = 32'h22;
    step();
    check_value("mis_fault",    32'(a_fault), 32'h1);
    check_value("mis_fault_pc", a_fault_pc, 32'h22);
    check_value("mis_pc",       a_pc, 32'h0);
    check_value("mis_valid",    32'(a_fetch_valid), 32'h0);
    check_value("mis_halted",   32'(a_halted), 32'h0);
    redirect_target = 32'h40;
    step();
    redirect = 1'b0;
    check_value("mis_pc_frozen", a_pc, 32'h0);
    check_value("mis_fpc_keep",  a_fault_pc, 32'h22);
    check_value("mis_cnt_keep",  32'(a_cnt), 32'h6);

    // Sentinel beats redirect
    do_reset();
    for (int i = 0; i < 5; i++) step();
    check_value("sen_pc14", a_pc, 32'h14);
    last_instr_flag = 1'b1; redirect = 1'b1; redirect_target = 32'h0;
    #1;
    check_value("sen_valid_comb", 32'(a_fetch_valid), 32'h0);
    step();
    check_value("sen_halted", 32'(a_halted), 32'h1);
    check_value("sen_pc",     a_pc, 32'h14);
    check_value("sen_fault",  32'(a_fault), 32'h0);
    check_value("sen_cnt",    32'(a_cnt), 32'h5);
    last_instr_flag = 1'b0;
    step();
    redirect = 1'b0;
    check_value("halt_pc_frozen", a_pc, 32'h14);
    check_value("halt_valid",     32'(a_fetch_valid), 32'h0);

    // Asynchronous reset mid-HALT
    #2 rst_n = 1'b0;
    #1;
    check_value("arst_halted", 32'(a_halted), 32'h0);
    check_value("arst_pc",     a_pc, 32'h0);
    check_value("arst_valid",  32'(a_fetch_valid), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_value("arst_run_pc4", a_pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
